alt_vipvfr130_prc_frame_scheduler: RTL and testbench
====================================================

# alt_vipvfr130_prc_frame_scheduler

Sequencer that drives the Packet Reader Component's 3-bit Avalon-MM control slave so that the PRC streams a continuous video sequence without per-packet host intervention. For every frame it programs and launches one control packet (type 15) followed by one video packet (type 0 by default) from a rotating set of frame buffers. It waits on the PRC completion interrupt, clears it, and advances. It sits between the host-facing configuration registers of the frame reader and the PRC slave port, in the PRC's clock domain.

## Interface
- NUM_BUFFERS, 3: number of frame-buffer base addresses supplied; legal 1..4.
- ADDR_WIDTH, 32: memory address width; matches PRC packet_addr.
- VIDEO_TYPE, 0: packet type written for video packets.
- CTRL_TYPE, 15: packet type written for control packets.

- clock  in  1  sole clock; same clock as PRC `clock`.
- reset  in  1  asynchronous, active-low reset.
- cfg_go  in  1  level; run while high.
- cfg_num_buffers  in  3  buffers in use; 0 treated as 1; values >NUM_BUFFERS clamp to NUM_BUFFERS.
- cfg_buf_addr  in  NUM_BUFFERS*ADDR_WIDTH  packed buffer bases; buffer i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cfg_ctrl_addr  in  ADDR_WIDTH  control-packet address.
- cfg_ctrl_samples, cfg_ctrl_words  in  32 each  control-packet length.
- cfg_video_samples, cfg_video_words  in  32 each  video-packet length.
- prc_address  out  3  to PRC control slave.
- prc_write  out  1  single-cycle write strobe; PRC slave has no waitrequest.
- prc_writedata  out  32  write data.
- prc_irq  in  1  PRC completion interrupt.
- busy  out  1  high from leaving IDLE to returning to IDLE.
- cur_buffer  out  2  index of buffer of the current/last video packet.
- frame_done  out  1  one-cycle pulse after a video packet's interrupt is cleared.
- frame_count  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- PRC register map used: 0 = control (bit0 GO), 2 = interrupt (write 1 clears), 3 = packet_addr, 4 = packet_type, 5 = packet_samples, 6 = packet_words.
- States: IDLE, WR_ADDR, WR_TYPE, WR_SAMPLES, WR_WORDS, WR_GO, WAIT_IRQ, WR_CLR. A packet-select flag `pkt` (0 = control, 1 = video) chooses the data source.
- IDLE: if cfg_go is sampled high, snapshot all cfg_* inputs into frame registers, set pkt=0, go to WR_ADDR. Config changes mid-frame take effect at the next frame.
- WR_ADDR→WR_TYPE→WR_SAMPLES→WR_WORDS→WR_GO: one write per cycle to addresses 3, 4, 5, 6, 0.
  - Data for WR_ADDR: address zero-extended to 32 bits.
  - Data for WR_TYPE: type in bits[3:0].
  - Data for WR_SAMPLES and WR_WORDS: the 32-bit length values.
  - Data for WR_GO: 32'h1.
- WAIT_IRQ: prc_write=0; stay until prc_irq=1, then WR_CLR (address 2, data 32'h1).
- After WR_CLR:
  - pkt=0: set pkt=1, go to WR_ADDR.
  - pkt=1: pulse frame_done, increment frame_count, set cur_buffer to (cur_buffer+1) mod effective count. If cfg_go=1, re-snapshot and go to WR_ADDR with pkt=0; else go to IDLE.
- Video address is frame_buf_addr[cur_buffer]. The first frame after reset uses buffer 0, and subsequent frames rotate. Leaving IDLE does not reset cur_buffer.
- Deasserting cfg_go never aborts a frame: the current control+video pair always completes.
- prc_irq already high on entry to WAIT_IRQ (stale) is accepted as completion. The five programming writes guarantee the previous clear has propagated.

## Timing
- Reset values: prc_address=0, prc_write=0, prc_writedata=0, busy=0, cur_buffer=0, frame_done=0, frame_count=0, state IDLE, pkt=0.
- Reset is asynchronous: asserting it mid-sequence drops prc_write in the same cycle with no partial-write cleanup. The PRC shares this reset.
- All outputs are registered.
- cfg_go high at edge N → first write (address 3) visible at edge N+1. busy rises with it.
- The packet write burst is 5 consecutive cycles.
- prc_irq high at edge M → clear write visible after edge M+1. For a video packet, frame_done is high during the cycle after that.
- Next frame's address-3 write follows frame_done in the same cycle as frame_done if cfg_go=1.
- Minimum frame overhead: 2×(5 writes + 1 clear) = 12 cycles plus 2 IRQ-wait cycles.

## Test plan
- Single frame: cfg_go pulses high for 1 cycle, and the PRC model raises irq 20 cycles after each GO.
  - Required writes in order: (3,ctrl_addr),(4,15),(5,ctrl_samples),(6,ctrl_words),(0,1),(2,1), then (3,buf0),(4,0),(5,video_samples),(6,video_words),(0,1),(2,1).
  - Then frame_done=1 once, frame_count=1, return to IDLE, busy=0.
- Rotation: cfg_go held, cfg_num_buffers=3, 7 frames → video addresses buf0,buf1,buf2,buf0,buf1,buf2,buf0; cur_buffer=1 at end.
- Clamp/zero: cfg_num_buffers=0 → every video packet uses buf0; cfg_num_buffers=7 with NUM_BUFFERS=3 → rotate over 3.
- Config snapshot: change cfg_video_samples from 100 to 200 during WAIT_IRQ of the control packet → that frame writes 100, next frame writes 200.
- Stop: drop cfg_go during the video-packet WAIT_IRQ → frame completes with clear write and frame_done, then IDLE with no further writes.
- Async reset: assert reset during WR_SAMPLES → prc_write=0 immediately and all outputs at reset values. After release with cfg_go=1, the sequence restarts from address 3 with ctrl_addr and buf0.

Source files
------------

// File: rtl/alt_vipvfr130_prc_frame_scheduler.sv
// Sequences PRC control-slave writes: one control packet plus one video packet per frame, rotating over frame buffers.
// Outputs are registered from next state; a PRC write appears the cycle after the decision; no backpressure (slave has no waitrequest).
module alt_vipvfr130_prc_frame_scheduler #(
  parameter int NUM_BUFFERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int VIDEO_TYPE  = 0,
  parameter int CTRL_TYPE   = 15
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cfg_go,
  input  logic [2:0]                        cfg_num_buffers,
  input  logic [NUM_BUFFERS*ADDR_WIDTH-1:0] cfg_buf_addr,
  input  logic [ADDR_WIDTH-1:0]             cfg_ctrl_addr,
  input  logic [31:0]                       cfg_ctrl_samples,
  input  logic [31:0]                       cfg_ctrl_words,
  input  logic [31:0]                       cfg_video_samples,
  input  logic [31:0]                       cfg_video_words,
  output logic [2:0]                        prc_address,
  output logic                              prc_write,
  output logic [31:0]                       prc_writedata,
  input  logic                              prc_irq,
  output logic                              busy,
  output logic [1:0]                        cur_buffer,
  output logic                              frame_done,
  output logic [15:0]                       frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_TYPE, S_WR_SAMPLES, S_WR_WORDS, S_WR_GO, S_WAIT_IRQ, S_WR_CLR
  } state_t;

  state_t state_q, state_d;
  logic   pkt_q, pkt_d;
  logic   snap;

  logic [ADDR_WIDTH-1:0] buf_q [NUM_BUFFERS];
  logic [ADDR_WIDTH-1:0] buf_d [NUM_BUFFERS];
  logic [ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [31:0]           ctrl_samples_q, ctrl_samples_d;
  logic [31:0]           ctrl_words_q, ctrl_words_d;
  logic [31:0]           video_samples_q, video_samples_d;
  logic [31:0]           video_words_q, video_words_d;
  logic [2:0]            nbuf_q, nbuf_d, nbuf_eff;

  logic [1:0]            cur_buffer_q, cur_buffer_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic [2:0]            prc_address_q, prc_address_d;
  logic                  prc_write_q, prc_write_d;
  logic [31:0]           prc_writedata_q, prc_writedata_d;
  logic [ADDR_WIDTH-1:0] vid_addr;

  // Zero buffers means one; anything beyond the instantiated set clamps to it.
  always_comb begin
    nbuf_eff = cfg_num_buffers;
    if (cfg_num_buffers == 3'd0)
      nbuf_eff = 3'd1;
    else if (cfg_num_buffers > 3'(NUM_BUFFERS))
      nbuf_eff = 3'(NUM_BUFFERS);
  end

  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    snap          = 1'b0;
    cur_buffer_d  = cur_buffer_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_go) begin
          snap    = 1'b1;
          pkt_d   = 1'b0;
          state_d = S_WR_ADDR;
        end
      end
      S_WR_ADDR:    state_d = S_WR_TYPE;
      S_WR_TYPE:    state_d = S_WR_SAMPLES;
      S_WR_SAMPLES: state_d = S_WR_WORDS;
      S_WR_WORDS:   state_d = S_WR_GO;
      S_WR_GO:      state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (prc_irq)
          state_d = S_WR_CLR;
      end
      S_WR_CLR: begin
        if (!pkt_q) begin
          pkt_d   = 1'b1;
          state_d = S_WR_ADDR;
        end else begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          cur_buffer_d  = (({1'b0, cur_buffer_q} + 3'd1) >= nbuf_q) ? 2'd0 : cur_buffer_q + 2'd1;
          if (cfg_go) begin
            snap    = 1'b1;
            pkt_d   = 1'b0;
            state_d = S_WR_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame registers: loaded only when a frame is launched, so mid-frame config edits wait for the next frame.
  always_comb begin
    for (int i = 0; i < NUM_BUFFERS; i++)
      buf_d[i] = snap ? cfg_buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : buf_q[i];
    ctrl_addr_d     = snap ? cfg_ctrl_addr     : ctrl_addr_q;
    ctrl_samples_d  = snap ? cfg_ctrl_samples  : ctrl_samples_q;
    ctrl_words_d    = snap ? cfg_ctrl_words    : ctrl_words_q;
    video_samples_d = snap ? cfg_video_samples : video_samples_q;
    video_words_d   = snap ? cfg_video_words   : video_words_q;
    nbuf_d          = snap ? nbuf_eff          : nbuf_q;
  end

  always_comb begin
    vid_addr = buf_d[0];
    for (int i = 0; i < NUM_BUFFERS; i++)
      if (cur_buffer_d == 2'(i))
        vid_addr = buf_d[i];
  end

  always_comb begin
    prc_address_d   = 3'd0;
    prc_write_d     = 1'b0;
    prc_writedata_d = 32'd0;
    busy_d          = (state_d != S_IDLE);
    case (state_d)
      S_WR_ADDR: begin
        prc_address_d   = 3'd3;
        prc_write_d     = 1'b1;
        prc_writedata_d = pkt_d ? 32'(vid_addr) : 32'(ctrl_addr_d);
      end
      S_WR_TYPE: begin
        prc_address_d   = 3'd4;
        prc_write_d     = 1'b1;
        prc_writedata_d = {28'd0, pkt_d ? 4'(VIDEO_TYPE) : 4'(CTRL_TYPE)};
      end
      S_WR_SAMPLES: begin
        prc_address_d   = 3'd5;
        prc_write_d     = 1'b1;
        prc_writedata_d = pkt_d ? video_samples_d : ctrl_samples_d;
      end
      S_WR_WORDS: begin
        prc_address_d   = 3'd6;
        prc_write_d     = 1'b1;
        prc_writedata_d = pkt_d ? video_words_d : ctrl_words_d;
      end
      S_WR_GO: begin
        prc_address_d   = 3'd0;
        prc_write_d     = 1'b1;
        prc_writedata_d = 32'h1;
      end
      S_WR_CLR: begin
        prc_address_d   = 3'd2;
        prc_write_d     = 1'b1;
        prc_writedata_d = 32'h1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pkt_q           <= 1'b0;
      for (int i = 0; i < NUM_BUFFERS; i++)
        buf_q[i] <= '0;
      ctrl_addr_q     <= '0;
      ctrl_samples_q  <= 32'd0;
      ctrl_words_q    <= 32'd0;
      video_samples_q <= 32'd0;
      video_words_q   <= 32'd0;
      nbuf_q          <= 3'd1;
      cur_buffer_q    <= 2'd0;
      frame_count_q   <= 16'd0;
      frame_done_q    <= 1'b0;
      busy_q          <= 1'b0;
      prc_address_q   <= 3'd0;
      prc_write_q     <= 1'b0;
      prc_writedata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      pkt_q           <= pkt_d;
      for (int i = 0; i < NUM_BUFFERS; i++)
        buf_q[i] <= buf_d[i];
      ctrl_addr_q     <= ctrl_addr_d;
      ctrl_samples_q  <= ctrl_samples_d;
      ctrl_words_q    <= ctrl_words_d;
      video_samples_q <= video_samples_d;
      video_words_q   <= video_words_d;
      nbuf_q          <= nbuf_d;
      cur_buffer_q    <= cur_buffer_d;
      frame_count_q   <= frame_count_d;
      frame_done_q    <= frame_done_d;
      busy_q          <= busy_d;
      prc_address_q   <= prc_address_d;
      prc_write_q     <= prc_write_d;
      prc_writedata_q <= prc_writedata_d;
    end
  end

  assign prc_address   = prc_address_q;
  assign prc_write     = prc_write_q;
  assign prc_writedata = prc_writedata_q;
  assign busy          = busy_q;
  assign cur_buffer    = cur_buffer_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_alt_vipvfr130_prc_frame_scheduler.sv
// Directed bench for the PRC frame scheduler with a small PRC slave model that logs writes and raises irq 20 cycles after GO.
module tb_alt_vipvfr130_prc_frame_scheduler;

  localparam logic [31:0] CA  = 32'h1000_0000;
  localparam logic [31:0] BA0 = 32'hA000_0000;
  localparam logic [31:0] BA1 = 32'hB000_0100;
  localparam logic [31:0] BA2 = 32'hC000_0200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_go = 1'b0;
  logic [2:0]  cfg_num_buffers = 3'd3;
  logic [95:0] cfg_buf_addr = {BA2, BA1, BA0};
  logic [31:0] cfg_ctrl_addr = CA;
  logic [31:0] cfg_ctrl_samples = 32'd3;
  logic [31:0] cfg_ctrl_words = 32'd2;
  logic [31:0] cfg_video_samples = 32'd100;
  logic [31:0] cfg_video_words = 32'd50;
  logic [2:0]  prc_address;
  logic        prc_write;
  logic [31:0] prc_writedata;
  logic        prc_irq = 1'b0;
  logic        busy;
  logic [1:0]  cur_buffer;
  logic        frame_done;
  logic [15:0] frame_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0]  la [$];
  logic [31:0] ld [$];
  int          fd_cnt = 0;
  int          irq_cnt = 0;

  logic [2:0]  ea [12] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd2};
  logic [31:0] ed [12] = '{CA, 32'd15, 32'd3, 32'd2, 32'd1, 32'd1, BA0, 32'd0, 32'd100, 32'd50, 32'd1, 32'd1};

  alt_vipvfr130_prc_frame_scheduler #(
    .NUM_BUFFERS(3), .ADDR_WIDTH(32), .VIDEO_TYPE(0), .CTRL_TYPE(15)
  ) dut (
    .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_num_buffers(cfg_num_buffers),
    .cfg_buf_addr(cfg_buf_addr), .cfg_ctrl_addr(cfg_ctrl_addr),
    .cfg_ctrl_samples(cfg_ctrl_samples), .cfg_ctrl_words(cfg_ctrl_words),
    .cfg_video_samples(cfg_video_samples), .cfg_video_words(cfg_video_words),
    .prc_address(prc_address), .prc_write(prc_write), .prc_writedata(prc_writedata),
    .prc_irq(prc_irq), .busy(busy), .cur_buffer(cur_buffer),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // PRC slave model: observes one bus cycle per clock, away from the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        prc_irq = 1'b0;
        irq_cnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) prc_irq = 1'b1;
        end
        if (frame_done) fd_cnt++;
        if (prc_write) begin
          la.push_back(prc_address);
          ld.push_back(prc_writedata);
          if (prc_address == 3'd0 && prc_writedata[0]) irq_cnt = 20;
          if (prc_address == 3'd2 && prc_writedata[0]) prc_irq = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    cfg_go = 1'b0;
    reset  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    la.delete();
    ld.delete();
    reset = 1'b1;
  endtask

  task automatic wait_log(input int n);
    int c = 0;
    while (la.size() < n && c < 3000) begin
      @(negedge clock);
      c++;
    end
    if (la.size() < n) chk("wait_log_timeout", la.size(), n);
  endtask

  task automatic wait_fd(input int n);
    int c = 0;
    while (fd_cnt < n && c < 3000) begin
      @(negedge clock);
      c++;
    end
    if (fd_cnt < n) chk("wait_fd_timeout", fd_cnt, n);
  endtask

  // Holds go for n (>=2) frames, dropping it once the last frame has launched.
  task automatic run_frames(input int n);
    int base;
    base   = fd_cnt;
    cfg_go = 1'b1;
    wait_fd(base + n - 1);
    cfg_go = 1'b0;
    wait_fd(base + n);
    repeat (10) @(negedge clock);
  endtask

  initial begin
    int base;
    // Reset values
    #2;
    chk("rst_write", prc_write, 0);
    chk("rst_addr", prc_address, 0);
    chk("rst_data", prc_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur", cur_buffer, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    apply_reset();

    // Single frame from a one-cycle go pulse
    @(posedge clock); #1 cfg_go = 1'b1;
    @(posedge clock); #1 cfg_go = 1'b0;
    chk("first_write", prc_write, 1);
    chk("first_addr", prc_address, 3);
    chk("first_busy", busy, 1);
    base = fd_cnt;
    wait_fd(base + 1);
    repeat (30) @(negedge clock);
    chk("single_nwr", la.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < la.size()) begin
        chk($sformatf("single_a%0d", i), la[i], ea[i]);
        chk($sformatf("single_d%0d", i), ld[i], ed[i]);
      end
    end
    chk("single_fd", fd_cnt - base, 1);
    chk("single_count", frame_count, 1);
    chk("single_busy", busy, 0);
    chk("single_cur", cur_buffer, 1);

    // Rotation over three buffers
    apply_reset();
    cfg_num_buffers = 3'd3;
    run_frames(7);
    chk("rot_nwr", la.size(), 84);
    if (la.size() >= 84) begin
      chk("rot_v0", ld[6],  BA0);
      chk("rot_v1", ld[18], BA1);
      chk("rot_v2", ld[30], BA2);
      chk("rot_v3", ld[42], BA0);
      chk("rot_v4", ld[54], BA1);
      chk("rot_v5", ld[66], BA2);
      chk("rot_v6", ld[78], BA0);
    end
    chk("rot_cur", cur_buffer, 1);
    chk("rot_count", frame_count, 7);

    // Zero buffers behaves as one
    apply_reset();
    cfg_num_buffers = 3'd0;
    run_frames(3);
    chk("zero_nwr", la.size(), 36);
    if (la.size() >= 36) begin
      chk("zero_v0", ld[6],  BA0);
      chk("zero_v1", ld[18], BA0);
      chk("zero_v2", ld[30], BA0);
    end
    chk("zero_cur", cur_buffer, 0);

    // Oversized count clamps to three
    apply_reset();
    cfg_num_buffers = 3'd7;
    run_frames(4);
    if (la.size() >= 48) begin
      chk("clamp_v0", ld[6],  BA0);
      chk("clamp_v1", ld[18], BA1);
      chk("clamp_v2", ld[30], BA2);
      chk("clamp_v3", ld[42], BA0);
    end else chk("clamp_nwr", la.size(), 48);
    chk("clamp_cur", cur_buffer, 1);

    // Mid-frame config change lands on the following frame
    apply_reset();
    cfg_num_buffers   = 3'd3;
    cfg_video_samples = 32'd100;
    base   = fd_cnt;
    cfg_go = 1'b1;
    wait_log(5);
    cfg_video_samples = 32'd200;
    wait_fd(base + 1);
    cfg_go = 1'b0;
    wait_fd(base + 2);
    repeat (10) @(negedge clock);
    if (la.size() >= 24) begin
      chk("snap_f0_addr", la[8], 5);
      chk("snap_f0", ld[8], 100);
      chk("snap_f1_addr", la[20], 5);
      chk("snap_f1", ld[20], 200);
    end else chk("snap_nwr", la.size(), 24);
    cfg_video_samples = 32'd100;

    // Dropping go during the video wait still finishes the frame
    apply_reset();
    base   = fd_cnt;
    cfg_go = 1'b1;
    wait_log(11);
    cfg_go = 1'b0;
    wait_fd(base + 1);
    repeat (40) @(negedge clock);
    chk("stop_nwr", la.size(), 12);
    if (la.size() >= 12) begin
      chk("stop_last_a", la[11], 2);
      chk("stop_last_d", ld[11], 1);
    end
    chk("stop_fd", fd_cnt - base, 1);
    chk("stop_busy", busy, 0);

    // Async reset during the second frame's samples write
    apply_reset();
    base   = fd_cnt;
    cfg_go = 1'b1;
    wait_fd(base + 1);
    wait_log(15);
    chk("prerst_write", prc_write, 1);
    chk("prerst_addr", prc_address, 5);
    chk("prerst_count", frame_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_write", prc_write, 0);
    chk("arst_addr", prc_address, 0);
    chk("arst_data", prc_writedata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cur", cur_buffer, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_count", frame_count, 0);
    repeat (2) @(posedge clock);
    #1;
    la.delete();
    ld.delete();
    reset = 1'b1;
    wait_log(7);
    if (la.size() >= 7) begin
      chk("restart_a0", la[0], 3);
      chk("restart_d0", ld[0], CA);
      chk("restart_a6", la[6], 3);
      chk("restart_d6", ld[6], BA0);
    end
    cfg_go = 1'b0;
    wait_fd(fd_cnt + 1);
    repeat (10) @(negedge clock);
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
